// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between instruction fetch
// (IFU, read-only) and the load/store unit (LSU, read/write).
//
// Flow: IDLE arbitrates and accepts one request. REQ presents it downstream
// until mem_req_ready. WAIT waits for mem_resp_valid, then pulses the owner's
// resp_valid for one cycle. Only one transaction is outstanding at a time.
// A watchdog in WAIT forces an error response after TIMEOUT cycles
// (TIMEOUT = 0 disables it).
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   ifu_req_valid/ready/addr  fetch request handshake
//   ifu_resp_valid/rdata      fetch response (1-cycle pulse, data held)
//   lsu_req_valid/ready/addr/wen/wdata/wmask   load/store request handshake
//   lsu_resp_valid/rdata      load data / store ack (1-cycle pulse, data held)
//   mem_req_valid/ready/addr/wen/wdata/wmask   downstream request
//   mem_resp_valid/rdata      downstream response
//   err_timeout               1-cycle pulse when the watchdog fires
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hdeadbeaf);
  localparam logic [15:0]       TIMEOUT_CNT  = 16'(TIMEOUT);

  state_t              state_reg, state_next;
  logic                last_grant_lsu_reg;  // 1 = LSU was granted last
  logic                owner_lsu_reg;       // owner of the outstanding transaction
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [7:0]          wmask_reg;
  logic [15:0]         cnt_reg;
  logic                ifu_resp_valid_reg, lsu_resp_valid_reg, err_timeout_reg;
  logic [DATA_W-1:0]   ifu_rdata_reg, lsu_rdata_reg;

  logic grant_ifu, grant_lsu;
  logic take_resp, take_timeout;

  // Round-robin: on conflict the requester that did not win last time goes.
  assign grant_ifu = ifu_req_valid & (~lsu_req_valid | last_grant_lsu_reg);
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_lsu_reg);

  always_comb begin
    state_next    = state_reg;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    take_resp     = 1'b0;
    take_timeout  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Readies are held low while reset is asserted so every output is 0.
        if (!rst) begin
          ifu_req_ready = grant_ifu;
          lsu_req_ready = grant_lsu;
          if (grant_ifu || grant_lsu)
            state_next = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready)
          state_next = WAIT;
      end
      WAIT: begin
        // A response in the same cycle the counter expires takes priority.
        if (mem_resp_valid) begin
          take_resp  = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_reg == TIMEOUT_CNT)) begin
          take_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      last_grant_lsu_reg <= 1'b1;
      owner_lsu_reg      <= 1'b0;
      addr_reg           <= '0;
      wen_reg            <= 1'b0;
      wdata_reg          <= '0;
      wmask_reg          <= '0;
      cnt_reg            <= '0;
      ifu_resp_valid_reg <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      err_timeout_reg    <= 1'b0;
      ifu_rdata_reg      <= '0;
      lsu_rdata_reg      <= '0;
    end else begin
      state_reg          <= state_next;
      ifu_resp_valid_reg <= 1'b0;
      lsu_resp_valid_reg <= 1'b0;
      err_timeout_reg    <= 1'b0;

      if (ifu_req_ready || lsu_req_ready) begin
        owner_lsu_reg      <= lsu_req_ready;
        last_grant_lsu_reg <= lsu_req_ready;
        addr_reg           <= lsu_req_ready ? lsu_addr : ifu_addr;
        wen_reg            <= lsu_req_ready & lsu_wen;
        wdata_reg          <= lsu_req_ready ? lsu_wdata : '0;
        wmask_reg          <= lsu_req_ready ? lsu_wmask : 8'h00;
      end

      if (state_reg == REQ && mem_req_ready)
        cnt_reg <= '0;
      else if (state_reg == WAIT)
        cnt_reg <= cnt_reg + 16'd1;

      if (take_resp || take_timeout) begin
        if (owner_lsu_reg) begin
          lsu_resp_valid_reg <= 1'b1;
          lsu_rdata_reg      <= take_resp ? mem_rdata : TIMEOUT_DATA;
        end else begin
          ifu_resp_valid_reg <= 1'b1;
          ifu_rdata_reg      <= take_resp ? mem_rdata : TIMEOUT_DATA;
        end
        err_timeout_reg <= take_timeout;
      end
    end
  end

  assign mem_req_valid  = (state_reg == REQ);
  assign mem_addr       = addr_reg;
  assign mem_wen        = wen_reg;
  assign mem_wdata      = wdata_reg;
  assign mem_wmask      = wmask_reg;
  assign ifu_resp_valid = ifu_resp_valid_reg;
  assign ifu_rdata      = ifu_rdata_reg;
  assign lsu_resp_valid = lsu_resp_valid_reg;
  assign lsu_rdata      = lsu_rdata_reg;
  assign err_timeout    = err_timeout_reg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single shared data memory port of the NPC core (DPI-backed pmem or a later bus bridge).
- Shares that port between instruction fetch (IFU, read-only) and the load/store unit (LSU, read/write).
- Drives the port with a valid/ready request handshake, then waits for a response, so memory latency may be one or many cycles.
- Round-robin on conflict, one outstanding transaction, watchdog timeout with error flag.

Parameters:
- ADDR_W, 32, address width (matches `RegBus).
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles in WAIT before forced error response; 0 disables the watchdog. Range 0..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid, 1-cycle pulse
- ifu_rdata  out  DATA_W  fetch data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  8  store byte mask (pmem_write format)
- lsu_resp_valid  out  1  load data / store ack, 1-cycle pulse
- lsu_rdata  out  DATA_W  load raw word (LSU does extension)
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  ADDR_W  downstream address
- mem_wen  out  1  downstream write enable
- mem_wdata  out  DATA_W  downstream write data
- mem_wmask  out  8  downstream write mask
- mem_resp_valid  in  1  downstream response (read data or write ack)
- mem_rdata  in  DATA_W  downstream read data
- err_timeout  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; last_grant=LSU, so IFU wins the first conflict.
  - All outputs 0; latched request fields 0; counter 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, arbitration (combinational):
  - Only one valid requester: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Granted *_req_ready=1 this cycle only in IDLE; the other ready=0. No ready outside IDLE.
  - On handshake: latch owner, addr, wen, wdata, wmask. IFU requests latch wen=0 and wmask=0. Update last_grant; go to REQ.
- REQ:
  - mem_req_valid=1, driving the latched fields; they stay stable until mem_req_ready.
  - mem_req_ready=1: go to WAIT, clear counter.
  - No timeout in REQ.
- WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - mem_resp_valid=1: capture mem_rdata into the owner's rdata register. Owner's resp_valid=1 on the next cycle for exactly one cycle. Go to IDLE.
  - TIMEOUT≠0 and counter==TIMEOUT with no response:
    - err_timeout=1 next cycle.
    - Owner resp_valid=1 next cycle with rdata=32'hdeadbeaf.
    - Go to IDLE.
  - Response arriving in the same cycle the counter hits TIMEOUT wins: normal response, no error.
- Latency, zero-wait memory (ready and resp both immediate): handshake at cycle T, mem_req_valid at T+1, resp sampled at T+2, *_resp_valid at T+3.
- Back-to-back: the resp pulse cycle is an IDLE cycle, so a new grant is allowed in the same cycle as the previous resp pulse.
- Store responses: lsu_resp_valid pulses as an ack; lsu_rdata carries whatever mem_rdata held.
- rdata registers hold their value between pulses. Only the owner's register is updated.
- mem_resp_valid outside WAIT is ignored: no state change, no pulse.
- Reset mid-transaction: abort immediately to IDLE, no resp pulse, no error. A late downstream response after reset deassertion is ignored.
- Requesters may drop valid before ready without effect. Fields are sampled only at handshake.

Test Plan:
- Single IFU read, memory ready and resp immediate, mem_rdata=32'h00100093 -> ifu_req_ready at T, mem_req_valid only at T+1 with mem_addr=ifu_addr, ifu_resp_valid pulse at T+3, ifu_rdata=32'h00100093, lsu_resp_valid stays 0.
- Both requesters valid continuously from reset -> grant order IFU, LSU, IFU, LSU; each owner's resp routed correctly; no double grant.
- LSU store addr=32'h80000010, wdata=32'hcafef00d, wmask=8'h0f, mem_req_ready held low 3 cycles -> mem_* fields stable for 4 cycles with mem_wen=1; lsu_resp_valid pulses one cycle after the ack.
- TIMEOUT=4, no mem_resp_valid -> after 4 WAIT cycles err_timeout pulse and owner resp_valid with rdata=32'hdeadbeaf; next request is granted normally.
- Response in the same cycle the counter reaches TIMEOUT -> normal data returned, err_timeout stays 0.
- rst asserted while in WAIT, stray mem_resp_valid after release -> all outputs 0 immediately, no resp pulse, next request serviced normally.
